module_keypad_mult: RTL and testbench
=====================================

# module_keypad_mult

Parametrised operand-entry and multiply engine for the keypad calculator datapath. It consumes debounced key events from the keypad scanner and accumulates two unsigned decimal operands, A and B, each `W` bits wide. On ENTER of the second operand it runs a W-cycle sequential shift-add multiplier and holds the 2W-bit product for the display stage. It replaces the fixed 4-bit load FSM, operand registers and combinational product path.

## Interface
Parameters:
- `W`, default 8: operand width in bits; legal range 2..16. Product width is 2W.

Ports:
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `key_valid`  in  1: single-cycle strobe; one key event per assertion.
- `key_code`  in  4: key value, sampled only when `key_valid`=1.
  - 0x0–0x9 = decimal digit.
  - 0xA = ENTER.
  - 0xB = CLEAR.
  - 0xC–0xF = ignored.
- `a`  out  W: operand A register.
- `b`  out  W: operand B register.
- `prod`  out  2W: product register; written only on the MULT→DONE transition.
- `sel_b`  out  1: 1 while operand B is being entered.
- `busy`  out  1: 1 in MULT.
- `done`  out  1: 1 in DONE (level).
- `ovf`  out  1: sticky flag; set when a digit is rejected for overflow.

## Operation
- States: ENTER_A, ENTER_B, MULT, DONE. Reset state is ENTER_A.
- Reset values: all outputs 0.
- Digit d in ENTER_A or ENTER_B:
  - Compute n = 10·op + d at full width, using (op<<3)+(op<<1)+d.
  - If n ≤ 2^W−1, the active operand becomes n.
  - Otherwise the operand is unchanged and `ovf`←1.
- ENTER:
  - In ENTER_A → ENTER_B; `b` is already 0.
  - In ENTER_B → MULT. On that edge the internal registers load: multiplicand←`a`, multiplier←`b`, accumulator←0, counter←0.
  - In DONE: ignored.
- MULT, each cycle:
  - If multiplier[0]=1, accumulator += multiplicand<<counter.
  - Then multiplier >>= 1 and counter += 1.
  - After the W-th MULT cycle: `prod`←accumulator, state → DONE.
- Digit in DONE starts a new calculation on a single edge:
  - `a`←d, `b`←0, `ovf`←0, `prod`←0.
  - State → ENTER_A.
- CLEAR in any state, including MULT (aborts the multiply):
  - `a`, `b`, `prod`, `ovf` ← 0.
  - State → ENTER_A.
- During MULT every key except CLEAR is ignored. `a` and `b` stay stable during MULT and DONE.
- Unused key codes (0xC–0xF) never change state or registers.
- `ovf` is cleared only by CLEAR, reset, or the digit that starts a new calculation from DONE.
- Arithmetic is unsigned throughout.
- Operand 0 is legal; 0·x completes normally and gives `prod`=0.
- Counter width: $clog2(W+1).

## Timing
- All outputs are registered. There are no combinational paths from `key_*` to any output.
- A key sampled at edge t is reflected on the outputs after edge t.
- ENTER in ENTER_B at edge t:
  - `busy`=1 from t to t+W.
  - `prod` valid and `done`=1 after edge t+W.
  - Latency is exactly W cycles, independent of operand values.
- Back-to-back `key_valid` on consecutive cycles is supported; each event is processed in its own cycle.
- CLEAR and the W-th MULT cycle on the same edge: CLEAR wins. `prod`=0, state ENTER_A.
- Asserting `rst` mid-MULT immediately forces all outputs to 0. There is no partial product leakage after release.
- `rst` deasserts synchronously to `clk` externally. The block needs no reset synchroniser.

## Test plan
- **Basic multiply** (W=8): keys 1,2,ENTER,1,5,ENTER → `a`=12, `b`=15; `busy` high for 8 cycles; then `prod`=180, `done`=1.
- **Overflow** (W=8): keys 2,5,6 → `a`=25, `ovf`=1. Then 5 → `a`=255, `ovf` stays 1. Then ENTER,255,ENTER → `prod`=65025.
- **Zero and max** (W=4): keys 0,ENTER,9,ENTER → `prod`=0 after 4 cycles. Then CLEAR, 15·15 → `prod`=225.
- **CLEAR abort**: CLEAR issued on cycle 3 of MULT → `busy`=0, `prod`=0, `a`=`b`=0, state ENTER_A. Also CLEAR on the final MULT cycle → `prod`=0.
- **Restart from DONE**: after 7·6=42, key 3 → `a`=3, `b`=0, `prod`=0, `done`=0. ENTER, 0xD, 4, ENTER → 0xD ignored, `prod`=12.
- **Async reset mid-MULT**: pull `rst` low between clock edges → all outputs 0 without waiting for a clock edge. After release, keys 2,ENTER,3,ENTER → `prod`=6 after W cycles.

Source files
------------

// File: rtl/module_keypad_mult.sv
// Keypad operand entry (two unsigned decimal operands) and W-cycle shift-add
// multiplier that holds the 2W-bit product for the display stage.
module module_keypad_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [3:0]     key_code,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           sel_b,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {ST_ENTER_A, ST_ENTER_B, ST_MULT, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q, acc_d, prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             is_digit, is_enter, is_clear;
  logic [W-1:0]     op;
  logic [W+3:0]     op_ext, digit_n;
  logic             digit_ovf;
  logic [2*W-1:0]   mcand_ext, acc_next;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_enter = key_valid && (key_code == 4'hA);
  assign is_clear = key_valid && (key_code == 4'hB);

  // A digit in DONE starts a fresh operand, so it accumulates onto zero.
  assign op        = (state_q == ST_ENTER_B) ? b_q :
                     (state_q == ST_DONE)    ? '0  : a_q;
  assign op_ext    = {4'b0000, op};
  assign digit_n   = (op_ext << 3) + (op_ext << 1) + {{W{1'b0}}, key_code};
  assign digit_ovf = |digit_n[W+3:W];

  assign mcand_ext = {{W{1'b0}}, mcand_q};
  assign acc_next  = mplier_q[0] ? acc_q + (mcand_ext << cnt_q) : acc_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    if (is_clear) begin
      state_d = ST_ENTER_A;
      a_d     = '0;
      b_d     = '0;
      prod_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ENTER_A: begin
          if (is_digit) begin
            if (digit_ovf) ovf_d = 1'b1;
            else           a_d   = digit_n[W-1:0];
          end else if (is_enter) begin
            state_d = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (is_digit) begin
            if (digit_ovf) ovf_d = 1'b1;
            else           b_d   = digit_n[W-1:0];
          end else if (is_enter) begin
            state_d  = ST_MULT;
            mcand_d  = a_q;
            mplier_d = b_q;
            acc_d    = '0;
            cnt_d    = '0;
          end
        end
        ST_MULT: begin
          acc_d    = acc_next;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            prod_d  = acc_next;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (is_digit) begin
            state_d = ST_ENTER_A;
            a_d     = digit_ovf ? '0 : digit_n[W-1:0];
            ovf_d   = digit_ovf;
            b_d     = '0;
            prod_d  = '0;
          end
        end
        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the internal
  // multiplier registers are reset too so an aborted multiply leaves no residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign prod  = prod_q;
  assign ovf   = ovf_q;
  assign sel_b = (state_q == ST_ENTER_B);
  assign busy  = (state_q == ST_MULT);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_module_keypad_mult.sv
// Directed bench for module_keypad_mult: one W=8 and one W=4 instance,
// keys driven on the falling edge, outputs checked on the falling edge.
module tb_module_keypad_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        kv8 = 1'b0, kv4 = 1'b0;
  logic [3:0]  kc8 = 4'h0, kc4 = 4'h0;

  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        s8, bz8, d8, o8;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        s4, bz4, d4, o4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  module_keypad_mult #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .key_valid(kv8), .key_code(kc8),
    .a(a8), .b(b8), .prod(p8), .sel_b(s8), .busy(bz8), .done(d8), .ovf(o8)
  );

  module_keypad_mult #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .key_valid(kv4), .key_code(kc4),
    .a(a4), .b(b4), .prod(p4), .sel_b(s4), .busy(bz4), .done(d4), .ovf(o4)
  );

  // Called at a falling edge; the key is sampled on the following rising edge.
  task automatic press8(input logic [3:0] c);
    kv8 = 1'b1; kc8 = c;
    @(negedge clk);
    kv8 = 1'b0;
  endtask

  task automatic press4(input logic [3:0] c);
    kv4 = 1'b1; kc4 = c;
    @(negedge clk);
    kv4 = 1'b0;
  endtask

  // Counts falling edges with busy high until done rises (bounded).
  task automatic wait_done(input bit use4, output int nbusy);
    int guard = 0;
    nbusy = 0;
    while (!(use4 ? d4 : d8) && guard < 40) begin
      if (use4 ? bz4 : bz8) nbusy++;
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({a8, b8, p8, s8, bz8, d8, o8} !== '0) begin
      $display("FAIL reset_w8: got a=%0d b=%0d prod=%0d sel_b=%b busy=%b done=%b ovf=%b, want all 0",
               a8, b8, p8, s8, bz8, d8, o8);
      n_fail++;
    end
    n_checks++;
    if ({a4, b4, p4, s4, bz4, d4, o4} !== '0) begin
      $display("FAIL reset_w4: got a=%0d b=%0d prod=%0d, want all 0", a4, b4, p4);
      n_fail++;
    end
  endtask

  task automatic test_basic;
    int nb;
    press8(4'h1); press8(4'h2);
    n_checks++;
    if (a8 !== 8'd12) begin $display("FAIL basic_a: got %0d want 12", a8); n_fail++; end
    press8(4'hA);
    n_checks++;
    if (s8 !== 1'b1) begin $display("FAIL basic_sel_b: got %b want 1", s8); n_fail++; end
    press8(4'hE);  // unused code must not change anything
    press8(4'h1); press8(4'h5);
    n_checks++;
    if (b8 !== 8'd15) begin $display("FAIL basic_b: got %0d want 15", b8); n_fail++; end
    press8(4'hA);
    wait_done(1'b0, nb);
    n_checks++;
    if (nb !== 8) begin $display("FAIL basic_busy_cycles: got %0d want 8", nb); n_fail++; end
    n_checks++;
    if (p8 !== 16'd180 || d8 !== 1'b1) begin
      $display("FAIL basic_prod: got prod=%0d done=%b want 180/1", p8, d8); n_fail++;
    end
    n_checks++;
    if (a8 !== 8'd12 || b8 !== 8'd15) begin
      $display("FAIL basic_operands_held: got a=%0d b=%0d want 12/15", a8, b8); n_fail++;
    end
  endtask

  task automatic test_overflow;
    int nb;
    press8(4'hB);
    n_checks++;
    if ({a8, b8, p8, d8} !== '0) begin
      $display("FAIL clear_from_done: got a=%0d b=%0d prod=%0d done=%b want 0", a8, b8, p8, d8); n_fail++;
    end
    press8(4'h2); press8(4'h5); press8(4'h6);
    n_checks++;
    if (a8 !== 8'd25 || o8 !== 1'b1) begin
      $display("FAIL ovf_reject: got a=%0d ovf=%b want 25/1", a8, o8); n_fail++;
    end
    press8(4'h5);
    n_checks++;
    if (a8 !== 8'd255 || o8 !== 1'b1) begin
      $display("FAIL ovf_max: got a=%0d ovf=%b want 255/1", a8, o8); n_fail++;
    end
    press8(4'hA); press8(4'h2); press8(4'h5); press8(4'h5); press8(4'hA);
    wait_done(1'b0, nb);
    n_checks++;
    if (p8 !== 16'd65025 || nb !== 8) begin
      $display("FAIL ovf_prod: got prod=%0d busy_cycles=%0d want 65025/8", p8, nb); n_fail++;
    end
  endtask

  task automatic test_restart;
    int nb;
    press8(4'h7);  // from DONE of 255*255 with ovf set
    n_checks++;
    if (a8 !== 8'd7 || b8 !== 8'd0 || p8 !== 16'd0 || d8 !== 1'b0 || o8 !== 1'b0) begin
      $display("FAIL restart_digit: got a=%0d b=%0d prod=%0d done=%b ovf=%b want 7/0/0/0/0",
               a8, b8, p8, d8, o8); n_fail++;
    end
    press8(4'hA); press8(4'h6); press8(4'hA);
    wait_done(1'b0, nb);
    n_checks++;
    if (p8 !== 16'd42) begin $display("FAIL restart_42: got %0d want 42", p8); n_fail++; end
    press8(4'hA);  // ENTER in DONE is ignored
    n_checks++;
    if (d8 !== 1'b1 || p8 !== 16'd42) begin
      $display("FAIL done_enter_ignored: got done=%b prod=%0d want 1/42", d8, p8); n_fail++;
    end
    press8(4'h3);
    n_checks++;
    if (a8 !== 8'd3 || b8 !== 8'd0 || p8 !== 16'd0 || d8 !== 1'b0) begin
      $display("FAIL restart_3: got a=%0d b=%0d prod=%0d done=%b want 3/0/0/0", a8, b8, p8, d8); n_fail++;
    end
    press8(4'hA); press8(4'hD); press8(4'h4);
    n_checks++;
    if (b8 !== 8'd4) begin $display("FAIL ignored_code_b: got %0d want 4", b8); n_fail++; end
    press8(4'hA);
    wait_done(1'b0, nb);
    n_checks++;
    if (p8 !== 16'd12) begin $display("FAIL restart_12: got %0d want 12", p8); n_fail++; end
  endtask

  task automatic test_clear_abort;
    press8(4'hB); press8(4'h3); press8(4'hA); press8(4'h4); press8(4'hA);
    repeat (2) @(negedge clk);
    press8(4'hB);  // sampled on the edge ending MULT cycle 3
    n_checks++;
    if ({a8, b8, p8, s8, bz8, d8} !== '0) begin
      $display("FAIL clear_mid_mult: got a=%0d b=%0d prod=%0d sel_b=%b busy=%b done=%b want 0",
               a8, b8, p8, s8, bz8, d8); n_fail++;
    end
    press8(4'h5); press8(4'hA); press8(4'h5); press8(4'hA);
    repeat (7) @(negedge clk);
    press8(4'hB);  // coincides with the final MULT edge
    n_checks++;
    if (p8 !== 16'd0 || d8 !== 1'b0 || bz8 !== 1'b0 || a8 !== 8'd0) begin
      $display("FAIL clear_last_cycle: got prod=%0d done=%b busy=%b a=%0d want 0", p8, d8, bz8, a8); n_fail++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (p8 !== 16'd0 || d8 !== 1'b0) begin
      $display("FAIL clear_last_cycle_late: got prod=%0d done=%b want 0/0", p8, d8); n_fail++;
    end
  endtask

  task automatic test_zero_max;
    int nb;
    press4(4'h0); press4(4'hA); press4(4'h9); press4(4'hA);
    wait_done(1'b1, nb);
    n_checks++;
    if (p4 !== 8'd0 || d4 !== 1'b1 || nb !== 4) begin
      $display("FAIL w4_zero: got prod=%0d done=%b busy_cycles=%0d want 0/1/4", p4, d4, nb); n_fail++;
    end
    press4(4'hB); press4(4'h1); press4(4'h6);
    n_checks++;
    if (a4 !== 4'd1 || o4 !== 1'b1) begin
      $display("FAIL w4_ovf: got a=%0d ovf=%b want 1/1", a4, o4); n_fail++;
    end
    press4(4'h5);
    n_checks++;
    if (a4 !== 4'd15) begin $display("FAIL w4_a15: got %0d want 15", a4); n_fail++; end
    press4(4'hA); press4(4'h1); press4(4'h5); press4(4'hA);
    wait_done(1'b1, nb);
    n_checks++;
    if (p4 !== 8'd225 || nb !== 4) begin
      $display("FAIL w4_max: got prod=%0d busy_cycles=%0d want 225/4", p4, nb); n_fail++;
    end
  endtask

  task automatic test_async_reset;
    int nb;
    press8(4'hB); press8(4'h9); press8(4'hA); press8(4'h9); press8(4'hA);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({a8, b8, p8, s8, bz8, d8, o8} !== '0) begin
      $display("FAIL async_reset: got a=%0d b=%0d prod=%0d busy=%b done=%b want all 0",
               a8, b8, p8, bz8, d8); n_fail++;
    end
    @(negedge clk);
    rst = 1'b1;
    press8(4'h2); press8(4'hA); press8(4'h3); press8(4'hA);
    wait_done(1'b0, nb);
    n_checks++;
    if (p8 !== 16'd6 || nb !== 8) begin
      $display("FAIL after_reset_prod: got prod=%0d busy_cycles=%0d want 6/8", p8, nb); n_fail++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_basic;
    test_overflow;
    test_restart;
    test_clear_abort;
    test_zero_max;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
